apb_mst_bridge: RTL and testbench

- Converts single-outstanding reg_native_if requests (req_vld/ack_vld handshake) into APB3 initiator transfers.
- It is the initiator-side counterpart of the APB responder in regmst_reg_top.
- Lets a native-bus agent, such as a regslv forwarding port or a debug engine, drive any APB slave in the register tree.
- Adds a PREADY watchdog and a global synchronous reset abort.

---
 rtl/apb_mst_pkg.sv | 16 +
 rtl/apb_mst_wdt.sv | 36 +++
 rtl/apb_mst_bridge.sv | 120 ++++++++++++
 tb/tb_apb_mst_bridge.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mst_pkg.sv
// Shared types and helpers for the native-to-APB3 initiator bridge.
package apb_mst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  // Watchdog counter width; must hold the value TIMEOUT_CYCLES itself.
  function automatic int unsigned wdt_cnt_width(input int unsigned timeout_cycles);
    return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_mst_wdt.sv
// PREADY watchdog: counts enabled cycles, saturates at TIMEOUT_CYCLES and
// flags expiry. With TIMEOUT_CYCLES=0 there is no counter and expire stays low.
module apb_mst_wdt
  import apb_mst_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expire
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, clr, en};
    assign expire        = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = wdt_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q;

    // Saturating wait-cycle counter; clear has priority over enable.
    always_ff @(posedge clk) begin
      if (clr) begin
        cnt_q <= '0;
      end else if (en && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign expire = (cnt_q == CntMax);
  end

endmodule

// File: rtl/apb_mst_bridge.sv
// Native reg_native_if (req_vld/ack_vld) to APB3 initiator bridge with a
// PREADY watchdog and a synchronous soft-reset abort.
module apb_mst_bridge
  import apb_mst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  fsm_clk,
  input  logic                  fsm_rst,
  input  logic                  global_sync_reset_in,
  input  logic                  req_vld,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  err,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  apb_mst_state_e state_q;
  logic           soft_rst;
  logic           wdt_clr;
  logic           wdt_en;
  logic           wdt_expire;

  assign soft_rst = fsm_rst | global_sync_reset_in;
  assign wdt_clr  = soft_rst | (state_q == RESP);
  assign wdt_en   = (state_q == ACCESS) & ~PREADY;

  apb_mst_wdt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk   (fsm_clk),
    .clr   (wdt_clr),
    .en    (wdt_en),
    .expire(wdt_expire)
  );

  // Transfer FSM with registered native and APB outputs.
  always_ff @(posedge fsm_clk) begin
    if (soft_rst) begin
      state_q <= IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      ack_vld <= 1'b0;
      rd_data <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack_vld <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_vld) begin
            if (wr_en ^ rd_en) begin
              PADDR   <= addr;
              PWRITE  <= wr_en;
              PWDATA  <= wr_en ? wr_data : '0;
              PSEL    <= 1'b1;
              PENABLE <= 1'b0;
              busy    <= 1'b1;
              state_q <= SETUP;
            end else begin
              // Ambiguous direction: complete immediately with an error.
              err     <= 1'b1;
              rd_data <= '0;
              ack_vld <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          // PREADY is checked first so it wins over a same-cycle expiry.
          if (PREADY) begin
            rd_data <= PWRITE ? '0 : PRDATA;
            err     <= PSLVERR;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            busy    <= 1'b0;
            ack_vld <= 1'b1;
            state_q <= RESP;
          end else if (wdt_expire) begin
            rd_data <= '0;
            err     <= 1'b1;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            busy    <= 1'b0;
            ack_vld <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mst_bridge.sv
// Scoreboard bench for apb_mst_bridge with a behavioural APB responder.
module tb_apb_mst_bridge;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 32;

  typedef struct {
    logic          err;
    logic [DW-1:0] rd;
    int            lat;
    int            pen;
    logic          apb;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wd;
    int            issue;
  } exp_t;

  logic          fsm_clk = 1'b0;
  logic          fsm_rst = 1'b1;
  logic          global_sync_reset_in = 1'b0;
  logic          req_vld = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          ack_vld;
  logic [DW-1:0] rd_data;
  logic          err;
  logic          busy;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;

  // Responder controls.
  int            wait_states = 0;
  logic          hang = 1'b0;
  logic          slverr = 1'b0;
  int            wcnt = 0;
  logic [DW-1:0] mem [16];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  exp_t sb[$];

  // Monitor-side state.
  int            pen_cnt = 0;
  logic          saw_psel = 1'b0;
  logic [AW-1:0] ref_addr;
  logic          ref_wr;
  logic [DW-1:0] ref_wd;

  apb_mst_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .fsm_clk             (fsm_clk),
    .fsm_rst             (fsm_rst),
    .global_sync_reset_in(global_sync_reset_in),
    .req_vld             (req_vld),
    .wr_en               (wr_en),
    .rd_en               (rd_en),
    .addr                (addr),
    .wr_data             (wr_data),
    .ack_vld             (ack_vld),
    .rd_data             (rd_data),
    .err                 (err),
    .busy                (busy),
    .PSEL                (PSEL),
    .PENABLE             (PENABLE),
    .PWRITE              (PWRITE),
    .PADDR               (PADDR),
    .PWDATA              (PWDATA),
    .PREADY              (PREADY),
    .PRDATA              (PRDATA),
    .PSLVERR             (PSLVERR)
  );

  always #5 fsm_clk = ~fsm_clk;

  always @(posedge fsm_clk) cyc <= cyc + 1;

  assign PREADY  = PSEL && PENABLE && !hang && (wcnt == wait_states);
  assign PRDATA  = mem[PADDR[5:2]];
  assign PSLVERR = slverr;

  always @(posedge fsm_clk) begin
    if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !slverr) mem[PADDR[5:2]] <= PWDATA;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ack"},     64'(ack_vld), 64'd0);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_psel"},    64'(PSEL),    64'd0);
    chk({tag, "_penable"}, 64'(PENABLE), 64'd0);
    chk({tag, "_pwrite"},  64'(PWRITE),  64'd0);
    chk({tag, "_paddr"},   PADDR,        64'd0);
    chk({tag, "_pwdata"},  64'(PWDATA),  64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_err"},     64'(err),     64'd0);
  endtask

  task automatic issue(input logic w, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic e_err, input logic [DW-1:0] e_rd,
                       input int e_lat, input int e_pen);
    exp_t x;
    @(negedge fsm_clk);
    req_vld = 1'b1;
    wr_en   = w;
    rd_en   = r;
    addr    = a;
    wr_data = d;
    x.err   = e_err;
    x.rd    = e_rd;
    x.lat   = e_lat;
    x.pen   = e_pen;
    x.apb   = (w != r);
    x.addr  = a;
    x.wr    = w;
    x.wd    = w ? d : '0;
    x.issue = cyc + 1;
    sb.push_back(x);
    @(negedge fsm_clk);
    req_vld = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge fsm_clk);
      #1;
    end
    chk({tag, "_done"}, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: APB phase checks every cycle, scoreboard pop on each ack.
  always @(negedge fsm_clk) begin
    if (!fsm_rst && !global_sync_reset_in) begin
      chk("busy_vs_psel", 64'(busy), 64'(PSEL));
      if (PSEL && !PENABLE) begin
        ref_addr = PADDR;
        ref_wr   = PWRITE;
        ref_wd   = PWDATA;
        pen_cnt  = 0;
        saw_psel = 1'b1;
        if (sb.size() != 0) begin
          chk("setup_paddr",  PADDR,         sb[0].addr);
          chk("setup_pwrite", 64'(PWRITE),   64'(sb[0].wr));
          chk("setup_pwdata", 64'(PWDATA),   64'(sb[0].wd));
        end
      end
      if (PSEL && PENABLE) begin
        pen_cnt++;
        chk("access_paddr",  PADDR,       ref_addr);
        chk("access_pwrite", 64'(PWRITE), 64'(ref_wr));
        chk("access_pwdata", 64'(PWDATA), 64'(ref_wd));
      end
      if (ack_vld) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack at cycle %0d want none", cyc);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("ack_err",     64'(err),               64'(x.err));
          chk("ack_rd_data", 64'(rd_data),           64'(x.rd));
          chk("ack_latency", 64'(cyc - x.issue + 1), 64'(x.lat));
          chk("penable_cyc", 64'(pen_cnt),           64'(x.pen));
          chk("apb_started", 64'(saw_psel),          64'(x.apb));
          chk("ack_psel_low", 64'({PSEL, PENABLE, busy}), 64'd0);
        end
        pen_cnt  = 0;
        saw_psel = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[6] = 32'hAAAA_AAAA;

    repeat (3) @(negedge fsm_clk);
    check_reset("reset");
    fsm_rst = 1'b0;

    // Zero-wait write.
    issue(1'b1, 1'b0, 64'h10, 32'h1111_1111, 1'b0, 32'h0, 3, 1);
    wait_done("wr0");
    chk("mem_0x10", 64'(mem[4]), 64'h1111_1111);

    // Read with three wait states.
    wait_states = 3;
    issue(1'b0, 1'b1, 64'h18, 32'h0, 1'b0, 32'hAAAA_AAAA, 6, 4);
    wait_done("rd_wait3");

    // Same read with a request pulsed during ACCESS; it must be ignored.
    issue(1'b0, 1'b1, 64'h18, 32'h0, 1'b0, 32'hAAAA_AAAA, 6, 4);
    @(negedge fsm_clk);
    req_vld = 1'b1;
    wr_en   = 1'b1;
    addr    = 64'h30;
    wr_data = 32'h9999_9999;
    @(negedge fsm_clk);
    req_vld = 1'b0;
    wr_en   = 1'b0;
    wait_done("rd_ignored");
    repeat (3) @(negedge fsm_clk);
    chk("mem_0x30_untouched", 64'(mem[12]), 64'd0);
    wait_states = 0;

    // Slave error on a write, then a clean read.
    slverr = 1'b1;
    issue(1'b1, 1'b0, 64'h28, 32'hDEAD_BEEF, 1'b1, 32'h0, 3, 1);
    wait_done("slverr");
    slverr = 1'b0;
    issue(1'b0, 1'b1, 64'h10, 32'h0, 1'b0, 32'h1111_1111, 3, 1);
    wait_done("rd_after_err");

    // Watchdog timeout, then recovery.
    hang = 1'b1;
    issue(1'b0, 1'b1, 64'h18, 32'h0, 1'b1, 32'h0, 11, 9);
    wait_done("timeout");
    hang = 1'b0;
    issue(1'b1, 1'b0, 64'h14, 32'h5555_5555, 1'b0, 32'h0, 3, 1);
    wait_done("wr_after_to");
    issue(1'b0, 1'b1, 64'h14, 32'h0, 1'b0, 32'h5555_5555, 3, 1);
    wait_done("rd_after_to");

    // Illegal requests: both and neither direction.
    issue(1'b1, 1'b1, 64'h10, 32'h7777_7777, 1'b1, 32'h0, 1, 0);
    wait_done("illegal_both");
    issue(1'b0, 1'b0, 64'h10, 32'h0, 1'b1, 32'h0, 1, 0);
    wait_done("illegal_none");
    chk("mem_0x10_kept", 64'(mem[4]), 64'h1111_1111);

    // Soft-reset abort during ACCESS.
    hang = 1'b1;
    issue(1'b1, 1'b0, 64'h24, 32'h3333_3333, 1'b0, 32'h0, 3, 1);
    repeat (3) @(negedge fsm_clk);
    chk("abort_in_access", 64'({PSEL, PENABLE}), 64'd3);
    global_sync_reset_in = 1'b1;
    @(negedge fsm_clk);
    check_reset("abort");
    sb.delete();
    global_sync_reset_in = 1'b0;
    hang = 1'b0;
    repeat (4) @(negedge fsm_clk);
    chk("mem_0x24_untouched", 64'(mem[9]), 64'd0);
    issue(1'b1, 1'b0, 64'h20, 32'h2222_2222, 1'b0, 32'h0, 3, 1);
    wait_done("wr_after_abort");
    chk("mem_0x20", 64'(mem[8]), 64'h2222_2222);

    repeat (5) @(negedge fsm_clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
